hamming_code_encoder_tx: RTL
============================

Name: hamming_code_encoder_tx

Overview:
Transmit-side counterpart of the Hamming decoder path. It accepts an 11-bit message through a valid/ready handshake and encodes it into a 15-bit Hamming(15,11) codeword with even parity. It then serialises the codeword as a UART frame on a single line. The serial output drives the decoder top's serial input (msg_in_de) directly.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit period; must be >= 2.
MSG_W, 11, message width (fixed; shown for readability).
CW_W, 15, codeword width (fixed).

Ports:
clk_en  input  1  block clock; all state on rising edge.
rst_n_en  input  1  asynchronous, active-low reset.
msg_in_en  input  11  message to encode; sampled only at handshake.
msg_valid_en  input  1  msg_in_en holds a valid message.
msg_ready_en  output  1  block idle and able to accept a message.
tx_out_en  output  1  serial UART line, idle high.
busy_en  output  1  frame in progress; equals the inverse of msg_ready_en.

Behaviour:
- Reset (async assert, sync release): state IDLE, tx_out_en=1, msg_ready_en=1, busy_en=0, bit/baud counters=0, codeword register=0.
- Codeword layout (bit index = Hamming position - 1):
  - Bit [0]=p1, [1]=p2, [2]=d0, [3]=p4, [6:4]=d3..d1, [7]=p8, [14:8]=d10..d4.
  - p1 = d0^d1^d3^d4^d6^d8^d10.
  - p2 = d0^d2^d3^d5^d6^d9^d10.
  - p4 = d1^d2^d3^d7^d8^d9^d10.
  - p8 = d4^d5^d6^d7^d8^d9^d10.
- Handshake:
  - Transfer occurs when msg_valid_en and msg_ready_en are both 1 at a rising edge.
  - The codeword is computed combinationally from msg_in_en and registered on the transfer edge.
  - msg_ready_en drops the following cycle.
  - msg_valid_en while busy is ignored; nothing is queued.
- FSM states and transitions:
  - IDLE: line high. On transfer, go to START.
  - START: line 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: line = codeword[bit index], LSB first, for CLKS_PER_BIT cycles per bit. After index 14 completes, go to STOP.
  - STOP: line 1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - The start bit begins on the first cycle after the transfer edge.
  - A frame is 17*CLKS_PER_BIT cycles.
  - msg_ready_en re-asserts on the cycle after the last STOP cycle.
  - Back-to-back frames are therefore separated by exactly 1 idle-high cycle when valid is held high.
- Counters:
  - Baud counter is 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary.
  - Bit index is 0..14 and is cleared on entry to DATA.
- tx_out_en is registered; no combinational path from inputs to tx_out_en.
- Reset asserted mid-frame: immediately aborts. Line goes high and FSM returns to IDLE; no partial-frame completion.

Decomposition:
- Shared package hamming_pkg:
  - MSG_W=11, CW_W=15.
  - Parity-position localparams.
  - The four parity-coverage masks, also reused by the decoder for syndrome calculation.
  - FSM state encoding {IDLE, START, DATA, STOP}.
- One natural sub-module: hamming_encoder_15_11. It is purely combinational, 11-bit in, 15-bit out, and is unit-testable against the decoder.
- The UART serialiser/FSM lives in the top of this block.

Test Plan:
1. Reset, then msg 11'h000, CLKS_PER_BIT=4 -> start bit, 15 zero data bits, stop bit. Frame is 68 cycles long; ready returns 1 on cycle 69 after transfer.
2. msg 11'h001 -> codeword 15'h0007, so the data bits on the line are 1,1,1 followed by 12 zeros.
3. msg 11'h400 -> codeword 15'h408B; msg 11'h7FF -> codeword 15'h7FFF. Check each serial bit at mid-bit sample points.
4. Valid held high with two messages (11'h155 then 11'h2AA) -> two frames separated by exactly one idle-high cycle. Pulsing valid during frame 1 has no effect.
5. Assert rst_n_en low mid-DATA -> tx_out_en=1 and msg_ready_en=1 asynchronously. After release, a new frame transmits correctly.
6. Loopback through hamming_code_decoder_top with matching baud and a random 11-bit message. Flip one line bit mid-frame -> decoder output equals the original message.

Source files
------------

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared Hamming(15,11) constants, parity masks and TX FSM encoding
//
// Purpose: widths, parity bit positions and parity-coverage masks used by both
// the encoder and the decoder (for syndrome calculation), plus the serialiser
// state encoding.
// Ports: none (package).
package hamming_pkg;

  localparam int MSG_W = 11;
  localparam int CW_W  = 15;

  // Codeword bit index of each parity bit (Hamming position - 1).
  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int P4_POS = 3;
  localparam int P8_POS = 7;

  // Bit i of a mask is set when Hamming position (i+1) has the matching
  // position bit set; XOR-reducing codeword & mask gives a parity or syndrome bit.
  localparam logic [CW_W-1:0] P1_MASK = 15'h5555;
  localparam logic [CW_W-1:0] P2_MASK = 15'h6666;
  localparam logic [CW_W-1:0] P4_MASK = 15'h7878;
  localparam logic [CW_W-1:0] P8_MASK = 15'h7F80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/hamming_encoder_15_11.sv
// rtl/hamming_encoder_15_11.sv - combinational Hamming(15,11) even-parity encoder
//
// Purpose: place the 11 data bits at the non-power-of-two Hamming positions and
// fill positions 1, 2, 4 and 8 with even parity over their coverage sets.
// Ports:
//   msg_in  input  [10:0]  message d10..d0
//   cw_out  output [14:0]  codeword, bit index = Hamming position - 1
module hamming_encoder_15_11
  import hamming_pkg::*;
(
  input  logic [MSG_W-1:0] msg_in,
  output logic [CW_W-1:0]  cw_out
);

  logic [CW_W-1:0] data_cw;

  always_comb begin
    data_cw       = '0;
    data_cw[2]    = msg_in[0];
    data_cw[6:4]  = msg_in[3:1];
    data_cw[14:8] = msg_in[10:4];

    // Parity slots are zero in data_cw, so masking the whole word is safe.
    cw_out         = data_cw;
    cw_out[P1_POS] = ^(data_cw & P1_MASK);
    cw_out[P2_POS] = ^(data_cw & P2_MASK);
    cw_out[P4_POS] = ^(data_cw & P4_MASK);
    cw_out[P8_POS] = ^(data_cw & P8_MASK);
  end

endmodule

// File: rtl/hamming_code_encoder_tx.sv
// rtl/hamming_code_encoder_tx.sv - Hamming(15,11) encoder with UART frame serialiser
//
// Purpose: accept an 11-bit message on a valid/ready handshake, encode it and
// send the 15-bit codeword LSB first as start + 15 data + stop bits.
// Ports:
//   clk_en        input        block clock, rising edge
//   rst_n_en      input        asynchronous active-low reset
//   msg_in_en     input  [10:0] message, sampled at handshake
//   msg_valid_en  input        message valid
//   msg_ready_en  output       idle, can accept a message
//   tx_out_en     output       registered serial line, idle high
//   busy_en       output       frame in progress (inverse of ready)
module hamming_code_encoder_tx
  import hamming_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk_en,
  input  logic             rst_n_en,
  input  logic [MSG_W-1:0] msg_in_en,
  input  logic             msg_valid_en,
  output logic             msg_ready_en,
  output logic             tx_out_en,
  output logic             busy_en
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_BIT = 4'(CW_W - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [CW_W-1:0]  cw_q, cw_d;
  logic             tx_q, tx_d;

  logic [CW_W-1:0]  enc_cw;
  logic             baud_done;

  hamming_encoder_15_11 u_encoder (
    .msg_in (msg_in_en),
    .cw_out (enc_cw)
  );

  assign baud_done    = (baud_q == BAUD_MAX);
  assign msg_ready_en = (state_q == ST_IDLE);
  assign busy_en      = ~msg_ready_en;
  assign tx_out_en    = tx_q;

  // tx_d is the line value for the next cycle, so each bit boundary loads the
  // upcoming bit's level and the line stays a pure flop output.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    cw_d      = cw_q;
    tx_d      = tx_q;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (msg_valid_en) begin
          cw_d    = enc_cw;
          baud_d  = '0;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = 4'd0;
          tx_d      = cw_q[0];
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == LAST_BIT) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            tx_d      = cw_q[bit_idx_d];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        baud_d  = '0;
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_en or negedge rst_n_en) begin
    if (!rst_n_en) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= 4'd0;
      cw_q      <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      cw_q      <= cw_d;
      tx_q      <= tx_d;
    end
  end

endmodule
